// File: rtl/phy_reg_freelist.sv
// Physical register free-list for rename: channel-compacted allocation, commit-side release, flush rewind.
// Optional statistics (stall_cycles, min_free) are built only when FREELIST_STAT_EN is defined.
module phy_reg_freelist #(
  parameter int PHY_REG_NUM  = 64,
  parameter int ARCH_REG_NUM = 32,
  parameter int RENAME_WIDTH = 4,
  parameter int COMMIT_WIDTH = 4,
  localparam int PW          = $clog2(PHY_REG_NUM)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [RENAME_WIDTH-1:0]          alloc_valid,
  input  logic                             alloc_en,
  output logic [RENAME_WIDTH-1:0][PW-1:0]  new_phy_id,
  output logic [RENAME_WIDTH-1:0]          new_phy_id_valid,
  input  logic                             commit_en,
  input  logic [COMMIT_WIDTH-1:0]          commit_new_valid,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]  commit_old_id,
  input  logic [COMMIT_WIDTH-1:0]          commit_old_valid,
  input  logic                             flush,
  output logic [PW:0]                      free_count,
  output logic                             empty
`ifdef FREELIST_STAT_EN
  ,
  output logic [31:0]                      stall_cycles,
  output logic [PW:0]                      min_free
`endif
);

  localparam int PTR_W     = PW + 1;
  localparam int INIT_FREE = PHY_REG_NUM - ARCH_REG_NUM;

  logic [PW-1:0] free_list [PHY_REG_NUM];

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  logic [PW:0] spec_head, commit_head, tail;
  logic [PW:0] spec_head_next, commit_head_next, tail_next;
  logic [PW:0] n_alloc, n_retire, n_release;
  logic [COMMIT_WIDTH-1:0][PW-1:0] rel_idx;

  always_comb begin
    free_count = tail - spec_head;
    empty      = (free_count == '0);
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      new_phy_id[k]       = free_list[PW'(spec_head + PTR_W'(k))];
      new_phy_id_valid[k] = (PTR_W'(k) < free_count);
    end
  end

  // Releases are packed at tail in slot order, skipping slots without an old id.
  always_comb begin
    n_alloc   = '0;
    n_retire  = '0;
    n_release = '0;
    rel_idx   = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      if (alloc_en && !flush && alloc_valid[k] && new_phy_id_valid[k]) begin
        n_alloc = n_alloc + PTR_W'(1);
      end
    end
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      rel_idx[j] = PW'(tail + n_release);
      if (commit_en && commit_old_valid[j]) begin
        n_release = n_release + PTR_W'(1);
      end
      if (commit_en && commit_new_valid[j]) begin
        n_retire = n_retire + PTR_W'(1);
      end
    end
    commit_head_next = commit_head + n_retire;
    spec_head_next   = flush ? commit_head_next : (spec_head + n_alloc);
    tail_next        = tail + n_release;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= PTR_W'(INIT_FREE);
      for (int i = 0; i < PHY_REG_NUM; i++) begin
        free_list[i] <= (i < INIT_FREE) ? PW'(ARCH_REG_NUM + i) : '0;
      end
    end else begin
      spec_head   <= spec_head_next;
      commit_head <= commit_head_next;
      tail        <= tail_next;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (commit_en && commit_old_valid[j]) begin
          free_list[rel_idx[j]] <= commit_old_id[j];
        end
      end
      assert ((alloc_valid & (alloc_valid + RENAME_WIDTH'(1))) == '0)
        else $error("phy_reg_freelist: alloc_valid bits not contiguous from bit 0");
      assert (PTR_W'(tail_next - commit_head_next) <= PTR_W'(PHY_REG_NUM))
        else $error("phy_reg_freelist: release overflows the free list");
    end
  end

`ifdef FREELIST_STAT_EN
  logic        stall_now;
  logic [PW:0] free_next;

  assign stall_now = alloc_en && !flush && ((alloc_valid & ~new_phy_id_valid) != '0);
  assign free_next = tail_next - spec_head_next;

  // min_free tracks the post-edge count so it always equals the lowest free_count seen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
      min_free     <= PTR_W'(INIT_FREE);
    end else begin
      if (stall_now && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (free_next < min_free) begin
        min_free <= free_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_phy_reg_freelist.sv
// Self-checking bench for phy_reg_freelist: queue-based model of free and in-flight ids,
// per-cycle comparison plus literal pins for the reset, drain, release, flush and mid-run reset cases.
module tb_phy_reg_freelist;
  localparam int PW = 6;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] alloc_valid;
  logic alloc_en;
  logic [3:0][PW-1:0] new_phy_id;
  logic [3:0] new_phy_id_valid;
  logic commit_en;
  logic [3:0] commit_new_valid;
  logic [3:0][PW-1:0] commit_old_id;
  logic [3:0] commit_old_valid;
  logic flush;
  logic [PW:0] free_count;
  logic empty;
`ifdef FREELIST_STAT_EN
  logic [31:0] stall_cycles;
  logic [PW:0] min_free;
`endif

  int checks = 0;
  int passes = 0;
  int freeQ[$];
  int inflightQ[$];
  int mStall = 0;
  int mMin = 32;
  bit modelLive = 1'b0;

  phy_reg_freelist dut (
    .clk(clk),
    .rst(rst),
    .alloc_valid(alloc_valid),
    .alloc_en(alloc_en),
    .new_phy_id(new_phy_id),
    .new_phy_id_valid(new_phy_id_valid),
    .commit_en(commit_en),
    .commit_new_valid(commit_new_valid),
    .commit_old_id(commit_old_id),
    .commit_old_valid(commit_old_valid),
    .flush(flush),
    .free_count(free_count),
    .empty(empty)
`ifdef FREELIST_STAT_EN
    ,
    .stall_cycles(stall_cycles),
    .min_free(min_free)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Model: freeQ holds offerable ids in order; inflightQ holds allocated-but-unretired ids.
  task automatic modelStep();
    int na, nc, req;
    if (!rst) begin
      freeQ = {};
      inflightQ = {};
      for (int i = 0; i < 32; i++) freeQ.push_back(32 + i);
      mStall = 0;
      mMin = 32;
      modelLive = 1'b1;
    end else begin
      req = $countones(alloc_valid);
      na = 0;
      if (alloc_en && !flush) begin
        na = (req < freeQ.size()) ? req : freeQ.size();
        if (req > freeQ.size()) mStall++;
      end
      nc = commit_en ? $countones(commit_new_valid) : 0;
      for (int i = 0; i < na; i++) inflightQ.push_back(freeQ.pop_front());
      for (int i = 0; i < nc; i++) void'(inflightQ.pop_front());
      if (flush) begin
        while (inflightQ.size() > 0) freeQ.push_front(inflightQ.pop_back());
      end
      if (commit_en) begin
        for (int j = 0; j < 4; j++)
          if (commit_old_valid[j]) freeQ.push_back(int'(commit_old_id[j]));
      end
      if (freeQ.size() < mMin) mMin = freeQ.size();
    end
  endtask

  task automatic checkOutput();
    int sz;
    sz = freeQ.size();
    checkVal("free_count", longint'(free_count), sz);
    checkVal("empty", longint'(empty), (sz == 0) ? 1 : 0);
    for (int k = 0; k < 4; k++) begin
      checkVal($sformatf("valid%0d", k), longint'(new_phy_id_valid[k]), (k < sz) ? 1 : 0);
      if (k < sz) checkVal($sformatf("id%0d", k), longint'(new_phy_id[k]), freeQ[k]);
    end
`ifdef FREELIST_STAT_EN
    checkVal("stall_cycles", longint'(stall_cycles), mStall);
    checkVal("min_free", longint'(min_free), mMin);
`endif
  endtask

  always @(negedge clk) begin
    if (modelLive) checkOutput();
  end

  task automatic driveInputs(input bit rstN, input bit aEn, input logic [3:0] aV, input bit cEn,
                             input logic [3:0] nV, input logic [3:0][PW-1:0] ids,
                             input logic [3:0] oV, input bit fl);
    rst = rstN;
    alloc_en = aEn;
    alloc_valid = aV;
    commit_en = cEn;
    commit_new_valid = nV;
    commit_old_id = ids;
    commit_old_valid = oV;
    flush = fl;
  endtask

  task automatic stepClock();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit rstN, input bit aEn, input logic [3:0] aV, input bit cEn,
                               input logic [3:0] nV, input logic [3:0][PW-1:0] ids,
                               input logic [3:0] oV, input bit fl);
    driveInputs(rstN, aEn, aV, cEn, nV, ids, oV, fl);
    stepClock();
  endtask

  task automatic checkResetState(input string tag);
    checkVal({tag, "_id0"}, longint'(new_phy_id[0]), 32);
    checkVal({tag, "_id1"}, longint'(new_phy_id[1]), 33);
    checkVal({tag, "_id2"}, longint'(new_phy_id[2]), 34);
    checkVal({tag, "_id3"}, longint'(new_phy_id[3]), 35);
    checkVal({tag, "_valid"}, longint'(new_phy_id_valid), 15);
    checkVal({tag, "_free"}, longint'(free_count), 32);
    checkVal({tag, "_empty"}, longint'(empty), 0);
  endtask

  initial begin
    logic [3:0][PW-1:0] ids;
    logic [3:0][PW-1:0] none;
    none = '0;
    driveInputs(1'b0, 1'b0, 4'b0, 1'b0, 4'b0, none, 4'b0, 1'b0);

    // Scenario 1: reset
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 4'b0, 1'b0, 4'b0, none, 4'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0, 1'b0, 4'b0, none, 4'b0, 1'b0);
    checkResetState("s1");

    // Scenario 2: two channels consumed
    applyStimulus(1'b1, 1'b1, 4'b0011, 1'b0, 4'b0, none, 4'b0, 1'b0);
    checkVal("s2_id0", longint'(new_phy_id[0]), 34);
    checkVal("s2_id3", longint'(new_phy_id[3]), 37);
    checkVal("s2_free", longint'(free_count), 30);

    // Scenario 3: drain to 2, then over-request
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 4'b1111, 1'b0, 4'b0, none, 4'b0, 1'b0);
    checkVal("s3_free2", longint'(free_count), 2);
    applyStimulus(1'b1, 1'b1, 4'b1111, 1'b0, 4'b0, none, 4'b0, 1'b0);
    checkVal("s3_free0", longint'(free_count), 0);
    checkVal("s3_empty", longint'(empty), 1);
    checkVal("s3_valid", longint'(new_phy_id_valid), 0);
`ifdef FREELIST_STAT_EN
    checkVal("s3_stall", longint'(stall_cycles), 1);
    checkVal("s3_min", longint'(min_free), 0);
`endif

    // Scenario 4: release {5,9}; not visible until the next cycle
    ids = '0;
    ids[0] = 6'd5;
    ids[1] = 6'd9;
    driveInputs(1'b1, 1'b0, 4'b0, 1'b1, 4'b0, ids, 4'b0011, 1'b0);
    #1;
    checkVal("s4_same_free", longint'(free_count), 0);
    checkVal("s4_same_valid", longint'(new_phy_id_valid), 0);
    stepClock();
    checkVal("s4_id0", longint'(new_phy_id[0]), 5);
    checkVal("s4_id1", longint'(new_phy_id[1]), 9);
    checkVal("s4_free", longint'(free_count), 2);

    // Simultaneous alloc and release
    ids = '0;
    ids[0] = 6'd12;
    applyStimulus(1'b1, 1'b1, 4'b0001, 1'b1, 4'b0, ids, 4'b0001, 1'b0);
    checkVal("sim_free", longint'(free_count), 2);
    checkVal("sim_id0", longint'(new_phy_id[0]), 9);
    checkVal("sim_id1", longint'(new_phy_id[1]), 12);

    // Scenario 5: allocate 6, retire 2, flush retiring 1 more (same-cycle alloc dropped)
    applyStimulus(1'b0, 1'b0, 4'b0, 1'b0, 4'b0, none, 4'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'b1111, 1'b0, 4'b0, none, 4'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'b0011, 1'b0, 4'b0, none, 4'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0, 1'b1, 4'b0011, none, 4'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'b1111, 1'b1, 4'b0001, none, 4'b0, 1'b1);
    checkVal("s5_id0", longint'(new_phy_id[0]), 35);
    checkVal("s5_free", longint'(free_count), 29);
    ids = '0;
    ids[0] = 6'd20;
    applyStimulus(1'b1, 1'b1, 4'b0001, 1'b1, 4'b0, ids, 4'b0001, 1'b1);
    checkVal("s5_flush_rel_free", longint'(free_count), 30);

    // Mixed traffic, kept legal using the model's occupancy
    for (int i = 0; i < 40; i++) begin
      int nc, nr, room;
      bit cEn;
      cEn = (i % 6) != 5;
      nc = ((i % 4) < inflightQ.size()) ? (i % 4) : inflightQ.size();
      room = 64 - (freeQ.size() + inflightQ.size()) + nc;
      nr = ((i % 3) < room) ? (i % 3) : room;
      for (int j = 0; j < 4; j++) ids[j] = PW'((i * 7 + j * 13) % 64);
      applyStimulus(1'b1, 1'b1, 4'((1 << (i % 5)) - 1), cEn, 4'((1 << nc) - 1), ids,
                    4'((1 << nr) - 1), (i % 11) == 10);
    end

    // Scenario 6: reset asserted during alloc + release
    ids = '0;
    ids[0] = 6'd3;
    ids[1] = 6'd4;
    applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1, 4'b0011, ids, 4'b0011, 1'b0);
    checkResetState("s6");
`ifdef FREELIST_STAT_EN
    checkVal("s6_stall", longint'(stall_cycles), 0);
    checkVal("s6_min", longint'(min_free), 32);
`endif
    applyStimulus(1'b1, 1'b0, 4'b0, 1'b0, 4'b0, none, 4'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
